csr_trap_unit: RTL

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

---
 rtl/csr_trap_unit_pkg.sv | 44 ++++
 rtl/csr_trap_unit_irq_prio_enc.sv | 39 +++
 rtl/csr_trap_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR / trap unit: CSR addresses,
// cause codes, system-instruction kinds and the trap FSM state type.
package csr_trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Synchronous exception causes
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
  // Interrupt causes
  localparam logic [4:0] CAUSE_IRQ_SW     = 5'd3;
  localparam logic [4:0] CAUSE_IRQ_TIMER  = 5'd7;
  localparam logic [4:0] CAUSE_IRQ_EXT    = 5'd11;

  localparam logic [1:0] SYS_ECALL  = 2'd0;
  localparam logic [1:0] SYS_EBREAK = 2'd1;
  localparam logic [1:0] SYS_MRET   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  // Read view of mstatus: MPP is hardwired to machine mode
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  endfunction

endpackage

// File: rtl/csr_trap_unit_irq_prio_enc.sv
// Fixed-priority interrupt selector: highest-index local line first,
// then external, software, timer.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] irq_local,
  input  logic               irq_ext,
  input  logic               irq_sw,
  input  logic               irq_timer,
  output logic               valid,
  output logic [4:0]         cause
);
  import csr_trap_unit_pkg::*;

  // Later assignments override earlier ones, so sources go lowest priority first
  always_comb begin
    valid = 1'b0;
    cause = '0;
    if (irq_timer) begin
      valid = 1'b1;
      cause = CAUSE_IRQ_TIMER;
    end
    if (irq_sw) begin
      valid = 1'b1;
      cause = CAUSE_IRQ_SW;
    end
    if (irq_ext) begin
      valid = 1'b1;
      cause = CAUSE_IRQ_EXT;
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_local[i]) begin
        valid = 1'b1;
        cause = 5'(16 + i);
      end
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with synchronous trap / mret handling and an
// interrupt path that drains the pipeline before redirecting fetch.
module csr_trap_unit #(
  parameter int unsigned NUM_IRQ     = 16,
  parameter int unsigned FLUSH_DEPTH = 4,
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        csr_raddr,
  input  logic [11:0]        csr_waddr,
  input  logic               csr_wen,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic               advance,
  input  logic [31:0]        pc_id,
  input  logic               sys_req,
  input  logic [1:0]         sys_kind,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_sw,
  input  logic [NUM_IRQ-1:0] irq_local,
  input  logic               retire,
  output logic               flush,
  output logic               trap_redirect,
  output logic [31:0]        trap_target,
  output logic               int_taken
);
  import csr_trap_unit_pkg::*;

  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_WMASK  = LOCAL_MASK | 32'h0000_0888;
  localparam logic        VEC_OK     = (VECTORED_EN != 0);
  localparam logic [31:0] ALIGN4     = 32'hFFFF_FFFC;

  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [31:0] mip_w, rd_cur, wr_view, target_q, irq_target;
  logic        wr_ok, sync_redirect_q;

  trap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cause_q, cause_d, irq_cause;
  logic        irq_valid, sys_valid, take_sync, take_mret, take_irq, do_redirect;

  assign mip_w = {16'(irq_local), 4'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .irq_local (irq_local & mie_q[16 +: NUM_IRQ]),
    .irq_ext   (irq_ext   & mie_q[11]),
    .irq_sw    (irq_sw    & mie_q[3]),
    .irq_timer (irq_timer & mie_q[7]),
    .valid     (irq_valid),
    .cause     (irq_cause)
  );

  // Current read value of the addressed CSR
  always_comb begin
    case (csr_raddr)
      CSR_MSTATUS:   rd_cur = mstatus_view(st_mie, st_mpie);
      CSR_MISA:      rd_cur = MISA_VALUE;
      CSR_MIE:       rd_cur = mie_q;
      CSR_MTVEC:     rd_cur = mtvec_q;
      CSR_MSCRATCH:  rd_cur = mscratch_q;
      CSR_MEPC:      rd_cur = mepc_q;
      CSR_MCAUSE:    rd_cur = mcause_q;
      CSR_MTVAL:     rd_cur = mtval_q;
      CSR_MIP:       rd_cur = mip_w;
      CSR_MCYCLE:    rd_cur = mcycle_q[31:0];
      CSR_MCYCLEH:   rd_cur = mcycle_q[63:32];
      CSR_MINSTRET:  rd_cur = minstret_q[31:0];
      CSR_MINSTRETH: rd_cur = minstret_q[63:32];
      default:       rd_cur = '0;
    endcase
  end

  // Masked write data as it will read back; wr_ok flags a writable address
  always_comb begin
    wr_ok   = 1'b1;
    wr_view = csr_wdata;
    case (csr_waddr)
      CSR_MSTATUS: wr_view = mstatus_view(csr_wdata[3], csr_wdata[7]);
      CSR_MIE:     wr_view = csr_wdata & MIE_WMASK;
      CSR_MTVEC:   wr_view = {csr_wdata[31:2], 1'b0, csr_wdata[0] & VEC_OK};
      CSR_MEPC:    wr_view = csr_wdata & ALIGN4;
      CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: wr_view = csr_wdata;
      default:     wr_ok = 1'b0;
    endcase
  end

  // Trap FSM next state: sync traps and mret act in IDLE; interrupts drain first
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    take_sync   = 1'b0;
    take_mret   = 1'b0;
    take_irq    = 1'b0;
    do_redirect = 1'b0;
    sys_valid   = sys_req && (sys_kind != 2'd3);
    unique case (state_q)
      ST_IDLE: begin
        if (advance) begin
          if (sys_valid && sys_kind != SYS_MRET) begin
            take_sync = 1'b1;
          end else if (sys_valid) begin
            take_mret = 1'b1;
          end else if (st_mie && irq_valid) begin
            take_irq = 1'b1;
            cause_d  = irq_cause;
            cnt_d    = '0;
            state_d  = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Leave on the advance that brings the count to FLUSH_DEPTH, so an
        // unstalled drain spends exactly FLUSH_DEPTH cycles with flush high
        if (advance) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(FLUSH_DEPTH)) state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        do_redirect = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, drain counter and latched interrupt cause
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // CSR writes first; trap side effects are applied after so they win
  always_ff @(posedge clock) begin
    if (reset) begin
      st_mie          <= 1'b0;
      st_mpie         <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      target_q        <= '0;
      sync_redirect_q <= 1'b0;
      csr_rdata       <= '0;
    end else begin
      csr_rdata       <= (csr_wen && wr_ok && csr_waddr == csr_raddr) ? wr_view : rd_cur;
      sync_redirect_q <= take_sync | take_mret;
      if (csr_wen) begin
        case (csr_waddr)
          CSR_MSTATUS: begin
            st_mie  <= wr_view[3];
            st_mpie <= wr_view[7];
          end
          CSR_MIE:      mie_q      <= wr_view;
          CSR_MTVEC:    mtvec_q    <= wr_view;
          CSR_MSCRATCH: mscratch_q <= wr_view;
          CSR_MEPC:     mepc_q     <= wr_view;
          CSR_MCAUSE:   mcause_q   <= wr_view;
          CSR_MTVAL:    mtval_q    <= wr_view;
          default: ;
        endcase
      end
      if (take_sync) begin
        mepc_q   <= pc_id & ALIGN4;
        mcause_q <= {27'b0, (sys_kind == SYS_EBREAK) ? CAUSE_BREAKPOINT : CAUSE_ECALL_M};
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        target_q <= mtvec_q & ALIGN4;
      end
      if (take_mret) begin
        target_q <= mepc_q;
        st_mie   <= st_mpie;
        st_mpie  <= 1'b1;
      end
      if (take_irq) begin
        st_mpie <= 1'b1;
        st_mie  <= 1'b0;
      end
      if (do_redirect) begin
        mepc_q   <= pc_id & ALIGN4;
        mcause_q <= {1'b1, 26'b0, cause_q};
      end
    end
  end

  // 64-bit counters; a write to either half suppresses that cycle's increment
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_wen && csr_waddr == CSR_MCYCLE)       mcycle_q[31:0]  <= csr_wdata;
      else if (csr_wen && csr_waddr == CSR_MCYCLEH) mcycle_q[63:32] <= csr_wdata;
      else                                          mcycle_q        <= mcycle_q + 64'd1;
      if (csr_wen && csr_waddr == CSR_MINSTRET)       minstret_q[31:0]  <= csr_wdata;
      else if (csr_wen && csr_waddr == CSR_MINSTRETH) minstret_q[63:32] <= csr_wdata;
      else if (retire)                                minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign irq_target    = (mtvec_q & ALIGN4) + (mtvec_q[0] ? {25'b0, cause_q, 2'b00} : 32'd0);
  assign flush         = (state_q == ST_FLUSH);
  assign int_taken     = (state_q == ST_REDIRECT);
  assign trap_redirect = sync_redirect_q | int_taken;
  assign trap_target   = int_taken ? irq_target : target_q;

endmodule
